// File: rtl/dropout_pkg.sv
// -----------------------------------------------------------------------------
// dropout_pkg
// Shared constants and helpers for the LFSR dropout stage.
//   - LFSR width, Galois tap mask and per-channel seed multiplier
//   - derive_seed(): per-channel seed derivation with zero fix-up
//   - Q_FRAC_BITS: fractional bits of the Q4.4 keep-scale
// -----------------------------------------------------------------------------
package dropout_pkg;

    localparam int          LFSR_W      = 16;
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_MULT   = 16'h9E37;
    localparam int          Q_FRAC_BITS = 4;

    // Channel ch seed = base ^ ((ch+1)*SEED_MULT), truncated to 16 bits.
    // A Galois LFSR locks up at zero, so a zero result is forced to 1.
    function automatic logic [15:0] derive_seed(input logic [15:0] base,
                                                input int unsigned ch);
        logic [31:0] prod;
        logic [15:0] seed;
        prod = (ch + 32'd1) * {16'h0000, SEED_MULT};
        seed = base ^ prod[15:0];
        if (seed == 16'h0000) begin
            seed = 16'h0001;
        end
        return seed;
    endfunction

endpackage

// File: rtl/dropout_lfsr16.sv
// -----------------------------------------------------------------------------
// dropout_lfsr16
// One 16-bit Galois LFSR (shift right, taps LFSR_TAPS). Resets
// asynchronously to RESET_SEED; load has priority over step.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   load       reload state from load_value
//   load_value seed used on load (must be non-zero)
//   step       advance one LFSR step
//   state      current LFSR state
// -----------------------------------------------------------------------------
module dropout_lfsr16
    import dropout_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] state_reg;
    logic [15:0] state_next;

    // Galois step: shift right and fold the taps in when the LSB falls out.
    assign state_next = {1'b0, state_reg[15:1]} ^ (state_reg[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RESET_SEED;
        end else if (load) begin
            state_reg <= load_value;
        end else if (step) begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/lfsr_dropout_unit.sv
// -----------------------------------------------------------------------------
// lfsr_dropout_unit
// Streaming dropout stage with per-channel LFSRs, programmable threshold
// and mask hold over several beats, one registered output stage.
// Optional feature macro: DROPOUT_SCALE_EN (inverted-dropout scaling of
// kept values by cfg_scale, Q4.4, saturating).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_enable                 1 = training (dropout), 0 = pass-through
//   cfg_threshold              channel dropped when lfsr < threshold
//   cfg_hold_len               mask reused for hold_len+1 accepted beats
//   cfg_scale                  Q4.4 keep-scale (DROPOUT_SCALE_EN only)
//   seed_load, seed_value      reseed all LFSRs from seed_value
//   in_valid/in_ready/in_data  input stream
//   out_valid/out_ready/out_data/out_mask  output stream (mask 1 = kept)
// -----------------------------------------------------------------------------
module lfsr_dropout_unit
    import dropout_pkg::*;
#(
    parameter int          N_CH = 8,
    parameter int          DW   = 8,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_enable,
    input  logic [15:0]        cfg_threshold,
    input  logic [7:0]         cfg_hold_len,
    input  logic [7:0]         cfg_scale,
    input  logic               seed_load,
    input  logic [15:0]        seed_value,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_CH*DW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_CH*DW-1:0] out_data,
    output logic [N_CH-1:0]    out_mask
);

    logic [15:0]        lfsr_state [N_CH];
    logic [N_CH-1:0]    mask_fresh;
    logic [N_CH-1:0]    mask_sel;
    logic [N_CH-1:0]    mask_reg;
    logic [7:0]         hold_cnt_reg;
    logic               out_valid_reg;
    logic [N_CH*DW-1:0] out_data_reg;
    logic [N_CH-1:0]    out_mask_reg;
    logic [N_CH*DW-1:0] data_next;
    logic               accept;
    logic               refresh;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    // A new mask is drawn only on a training beat at the end of a hold window.
    assign refresh  = cfg_enable && (hold_cnt_reg == 8'd0);

    always_comb begin
        mask_sel = '1;
        if (cfg_enable) begin
            mask_sel = (hold_cnt_reg == 8'd0) ? mask_fresh : mask_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [DW-1:0] ch_data;
            logic [DW-1:0] ch_kept;

            dropout_lfsr16 #(
                .RESET_SEED (derive_seed(SEED, gi))
            ) u_lfsr (
                .clk        (clk),
                .reset      (reset),
                .load       (seed_load),
                .load_value (derive_seed(seed_value, gi)),
                .step       (accept && refresh),
                .state      (lfsr_state[gi])
            );

            assign mask_fresh[gi] = (lfsr_state[gi] >= cfg_threshold);
            assign ch_data        = in_data[gi*DW +: DW];

`ifdef DROPOUT_SCALE_EN
            logic [DW+7:0] ch_prod;
            logic [DW+7:0] ch_shift;
            assign ch_prod  = {8'h00, ch_data} * {{DW{1'b0}}, cfg_scale};
            assign ch_shift = ch_prod >> Q_FRAC_BITS;
            // Any bit above DW after the shift means overflow: saturate.
            assign ch_kept  = !cfg_enable ? ch_data :
                              (|ch_shift[DW+7:DW]) ? {DW{1'b1}} : ch_shift[DW-1:0];
`else
            assign ch_kept  = ch_data;
`endif
            assign data_next[gi*DW +: DW] = mask_sel[gi] ? ch_kept : {DW{1'b0}};
        end
    endgenerate

`ifndef DROPOUT_SCALE_EN
    logic unused_scale;
    assign unused_scale = ^cfg_scale;
`endif

    // Hold counter and mask register. seed_load overrides the accept path so
    // the beat after a reseed always draws a fresh mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_reg <= 8'd0;
            mask_reg     <= '0;
        end else begin
            if (accept && refresh) begin
                mask_reg <= mask_fresh;
            end
            if (seed_load) begin
                hold_cnt_reg <= 8'd0;
            end else if (accept) begin
                if (!cfg_enable) begin
                    hold_cnt_reg <= 8'd0;
                end else if (hold_cnt_reg == 8'd0) begin
                    hold_cnt_reg <= cfg_hold_len;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg - 8'd1;
                end
            end
        end
    end

    // Single output register stage; holds while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_mask_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_next;
            out_mask_reg  <= mask_sel;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_mask  = out_mask_reg;

endmodule

// File: doc/lfsr_dropout_unit.md
# lfsr_dropout_unit

Parametrised, synthesizable dropout stage for the neuron datapath. It uses a bank of per-channel 16-bit Galois LFSRs, a programmable drop threshold, and mask hold over multiple beats. It has valid/ready streaming with one registered output stage, and optional inverted-dropout scaling. It sits between a layer's activation output and the next layer's input. It runs in training mode and is transparent in inference mode.

## Interface
Parameters:
- N_CH, 8, number of neuron channels
- DW, 8, unsigned data width per channel
- SEED, 16'hACE1, default LFSR seed base, applied at reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- cfg_enable  in  1  1 = training (apply dropout), 0 = pass-through
- cfg_threshold  in  16  channel dropped when its LFSR state < cfg_threshold
- cfg_hold_len  in  8  mask reused for cfg_hold_len+1 accepted beats
- cfg_scale  in  8  unsigned Q4.4 keep-scale; used only with DROPOUT_SCALE_EN
- seed_load  in  1  single-cycle pulse; reseeds all LFSRs from seed_value
- seed_value  in  16  new seed base
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  N_CH*DW  channel i at [i*DW +: DW]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_data  out  N_CH*DW  dropped/scaled data
- out_mask  out  N_CH  1 = kept, 0 = dropped (for backprop)

## Operation
- LFSR: 16-bit Galois, taps 16'hB400, shift right. Its state is never 0.
- Channel i seed = base ^ ((i+1)*16'h9E37) truncated to 16 bits. A zero result is replaced with 16'h0001. The base is SEED at reset and seed_value on seed_load.
- Accept = in_valid && in_ready. Nothing changes without an accept, except seed_load and reset.
- On accept with cfg_enable=1:
  - If hold_cnt==0: mask_i = (lfsr_i >= cfg_threshold). Latch the mask into mask_reg, advance all LFSRs one step, and set hold_cnt <= cfg_hold_len.
  - Else: use mask_reg and decrement hold_cnt.
- On accept with cfg_enable=0: mask = all ones, no scaling, LFSRs frozen, hold_cnt <= 0.
- Dropped channel output = 0. Kept channel output = in_data channel, or the scaled value (see Configuration).
- cfg_threshold=0 never drops. cfg_threshold=16'hFFFF drops every channel except one whose state is 16'hFFFF.
- seed_load reloads the LFSRs and clears hold_cnt. The next accepted beat generates a fresh mask.
  - If seed_load coincides with an accept, that beat uses the old LFSR state. seed_load wins for the next state.
- Config inputs are sampled on accept. Changing them mid-hold does not alter mask_reg until the next refresh.

## Timing
- Reset values: out_valid=0, out_data=0, out_mask=0, mask_reg=0, hold_cnt=0, LFSRs = seeds from SEED. in_ready=1 after reset.
- in_ready = !out_valid || out_ready, combinational from out_ready.
- Latency: 1 cycle. A beat accepted at edge k is visible at out_* after edge k.
- Back-to-back throughput is 1 beat/cycle while out_ready=1.
- Output is held stable while out_valid && !out_ready.
- Reset asserted mid-stream discards the in-flight output beat immediately.

## Configuration
- DROPOUT_SCALE_EN defined: a kept value becomes (data*cfg_scale)>>4, saturated to 2^DW-1. The product is DW+8 bits wide and truncated toward zero.
  - Example: cfg_scale=8'h20 (2.0) for p=0.5.
- Not defined: kept values pass unmodified, cfg_scale is ignored, and no multipliers are synthesized.

## Structure
- Package dropout_pkg holds:
  - LFSR width (16), tap constant 16'hB400, seed multiplier 16'h9E37
  - the function for seed derivation and zero-fixup
  - the Q4.4 fraction-bit constant (4)
- Sub-module dropout_lfsr16: one LFSR with async reset to a seed, and load and step inputs. It is instantiated N_CH times in a generate loop.
- The top level holds the hold counter, mask register, scaling, and output register.

## Test plan
- cfg_enable=0, random in_data, out_ready=1 -> out_data == in_data delayed 1 cycle, out_mask=8'hFF, LFSR states unchanged.
- cfg_enable=1, cfg_threshold=0 -> out_data == in_data and out_mask=8'hFF every beat. cfg_threshold=16'hFFFF -> all channels 0, except any channel whose LFSR equals 16'hFFFF (checked against the reference model).
- cfg_threshold=16'h8000, cfg_hold_len=3, 16 beats -> mask changes only on beats 0, 4, 8, 12. Each mask matches the model LFSR comparison.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, no LFSR step. Then release -> the stream resumes with no beat lost or duplicated.
- seed_load on the same cycle as an accept with hold_cnt=2 -> the current beat uses the old mask. The next beat uses a fresh mask from the seed_value-derived states.
- DROPOUT_SCALE_EN, cfg_scale=8'h20, data 8'h50 -> 8'hA0. Data 8'h90 -> 8'hFF (saturated). A dropped channel -> 8'h00.
